// File: rtl/dm_abs_cmd.sv
// dm_abs_cmd: abstract-command sequencer; decodes `command`, runs the go/ack/done handshake, owns busy/cmderr.
// Define DM_ABS_POSTINC_EN to accept aampostincrement and emit arg1_inc pulses.
module dm_abs_cmd #(
    parameter int WAIT_TIMEOUT = 0,
    parameter int TO_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmactive,
    input  logic        cmd_valid,
    input  logic [31:0] cmd,
    input  logic        hart_halted,
    input  logic        hart_ack,
    input  logic        hart_done,
    input  logic        hart_exception,
    input  logic [2:0]  cmderr_clr,
    output logic        go,
    output logic [2:0]  routine,
    output logic [11:0] instr_fix,
    output logic        busy,
    output logic [2:0]  cmderr,
    output logic        arg1_inc,
    output logic [2:0]  arg1_inc_val
);
`ifdef DM_ABS_POSTINC_EN
    localparam logic POSTINC = 1'b1;
`else
    localparam logic POSTINC = 1'b0;
`endif
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GO   = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_BUSY  = 3'd1;
    localparam logic [2:0] ERR_UNSUP = 3'd2;
    localparam logic [2:0] ERR_EXC   = 3'd3;
    localparam logic [2:0] ERR_HALT  = 3'd4;

    logic [1:0]      state_q, state_d;
    logic            go_q, go_d, busy_q, busy_d;
    logic [2:0]      rt_q, rt_d, err_q, err_d;
    logic [11:0]     fix_q, fix_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            pinc_q, pinc_d, inc_q, inc_d;
    logic [2:0]      incv_q, incv_d;

    logic [7:0]  cmdtype;
    logic [2:0]  size;
    logic        postinc, postexec, transfer, write;
    logic [15:0] regno;
    logic        unused_bit;
    logic        is_gpr, is_csr, is_mem, noop, timeout;
    logic [2:0]  chk_err;

    assign cmdtype    = cmd[31:24];
    assign unused_bit = cmd[23];
    assign size       = cmd[22:20];
    assign postinc    = cmd[19];
    assign postexec   = cmd[18];
    assign transfer   = cmd[17];
    assign write      = cmd[16];
    assign regno      = cmd[15:0];

    assign is_mem  = cmdtype == 8'd2;
    assign is_gpr  = regno[15:5] == 11'h080;
    assign is_csr  = regno[15:12] == 4'h0;
    assign noop    = cmdtype == 8'd0 && !transfer && !postexec;
    assign timeout = WAIT_TIMEOUT != 0 && to_q == TO_W'(WAIT_TIMEOUT - 1);

    // First failing check in priority order; ERR_NONE means the command may run.
    assign chk_err = (cmdtype != 8'd0 && !is_mem)                                        ? ERR_UNSUP :
                     (!is_mem && (size != 3'd2 || postexec || !(is_gpr || is_csr)))      ? ERR_UNSUP :
                     (is_mem && (size > 3'd2 || (postinc && !POSTINC)))                  ? ERR_UNSUP :
                     !hart_halted                                                        ? ERR_HALT  : ERR_NONE;

    always_comb begin
        state_d = state_q;
        rt_d    = rt_q;
        fix_d   = fix_q;
        to_d    = to_q;
        pinc_d  = pinc_q;
        inc_d   = 1'b0;
        incv_d  = 3'd0;
        err_d   = err_q & ~cmderr_clr;
        if (state_q != IDLE && cmd_valid && err_q == ERR_NONE)
            err_d = ERR_BUSY;
        case (state_q)
            IDLE: if (cmd_valid && err_q == ERR_NONE && !noop) begin
                if (chk_err != ERR_NONE) begin
                    err_d = chk_err;
                end else begin
                    state_d = GO;
                    rt_d    = is_mem ? (write ? 3'd5 : 3'd6) : is_gpr ? (write ? 3'd1 : 3'd2) : (write ? 3'd3 : 3'd4);
                    fix_d   = is_mem ? {9'b0, size} : is_gpr ? {7'b0, regno[4:0]} : regno[11:0];
                    pinc_d  = POSTINC && is_mem && postinc;
                end
            end
            GO: if (hart_ack) begin
                state_d = WAIT;
                to_d    = '0;
            end
            WAIT: begin
                to_d = to_q + 1'b1;
                if (hart_exception || (timeout && !hart_done)) begin
                    err_d   = ERR_EXC;
                    state_d = IDLE;
                end else if (hart_done) begin
                    state_d = IDLE;
                    inc_d   = pinc_q;
                    incv_d  = pinc_q ? 3'b001 << fix_q[1:0] : 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!dmactive) begin
            state_d = IDLE;
            rt_d    = 3'd0;
            fix_d   = 12'd0;
            to_d    = '0;
            pinc_d  = 1'b0;
            inc_d   = 1'b0;
            incv_d  = 3'd0;
            err_d   = ERR_NONE;
        end
    end

    assign go_d   = state_d == GO;
    assign busy_d = state_d != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            rt_q    <= 3'd0;
            fix_q   <= 12'd0;
            err_q   <= 3'd0;
            to_q    <= '0;
            pinc_q  <= 1'b0;
            inc_q   <= 1'b0;
            incv_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            rt_q    <= rt_d;
            fix_q   <= fix_d;
            err_q   <= err_d;
            to_q    <= to_d;
            pinc_q  <= pinc_d;
            inc_q   <= inc_d;
            incv_q  <= incv_d;
        end
    end

    assign go           = go_q;
    assign busy         = busy_q;
    assign routine      = rt_q;
    assign instr_fix    = fix_q;
    assign cmderr       = err_q;
    assign arg1_inc     = inc_q;
    assign arg1_inc_val = incv_q;
endmodule
